// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-port memory between instruction fetch
// and the MEM-stage data port. Data has priority; a starvation counter lets a
// waiting fetch win after STARVE_MAX consecutive data grants, and a watchdog
// aborts a transaction the memory never completes.
module rv32_mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        d_we,
   input  logic [2:0]  d_width,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   output logic        m_req,
   output logic [31:0] m_addr,
   output logic        m_we,
   output logic [2:0]  m_width,
   output logic [31:0] m_wdata,
   input  logic        m_ready,
   input  logic [31:0] m_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        err
);

   localparam int unsigned SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int unsigned TCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);
   localparam logic [TCW-1:0] TCNT_LAST  = TCW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_D = 2'd1,
      BUSY_I = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [SCW-1:0] starve_cnt;
   logic [TCW-1:0] tcnt;
   logic           d_elig;
   logic           i_elig;
   logic           grant_d;
   logic           grant_i;
   logic           done;
   logic           abort;

   // The memory is driven exactly while a transaction is outstanding, so an
   // asynchronous reset of the state drops m_req immediately.
   assign m_req     = (state != IDLE);
   assign stall_if  = i_req & ~i_ack;
   assign stall_mem = d_req & ~d_ack;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Arbitration and completion decode; a port whose ack is high this cycle is
   // masked so its still-held request is not granted a second time.
   always_comb begin
      d_elig   = d_req & ~d_ack;
      i_elig   = i_req & ~i_ack;
      state_nx = state;
      grant_d  = 1'b0;
      grant_i  = 1'b0;
      done     = 1'b0;
      abort    = 1'b0;
      case (state)
         IDLE: begin
            if (d_elig && (!i_elig || starve_cnt != STARVE_LIM)) begin
               grant_d  = 1'b1;
               state_nx = BUSY_D;
            end else if (i_elig) begin
               grant_i  = 1'b1;
               state_nx = BUSY_I;
            end
         end
         BUSY_D, BUSY_I: begin
            if (m_ready) begin
               done     = 1'b1;
               state_nx = IDLE;
            end else if (tcnt == TCNT_LAST) begin
               done     = 1'b1;
               abort    = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Memory request registers, acks, read data, counters and sticky error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_addr     <= '0;
         m_we       <= 1'b0;
         m_width    <= '0;
         m_wdata    <= '0;
         d_ack      <= 1'b0;
         i_ack      <= 1'b0;
         d_rdata    <= '0;
         i_rdata    <= '0;
         err        <= 1'b0;
         starve_cnt <= '0;
         tcnt       <= '0;
      end else begin
         d_ack <= done && (state == BUSY_D);
         i_ack <= done && (state == BUSY_I);

         if (grant_d) begin
            m_addr  <= d_addr;
            m_we    <= d_we;
            m_width <= d_width;
            m_wdata <= d_wdata;
            if (!i_req)                      starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + SCW'(1);
         end

         if (grant_i) begin
            m_addr     <= i_addr;
            m_we       <= 1'b0;
            m_width    <= 3'b010;
            starve_cnt <= '0;
         end

         if (state != IDLE) begin
            if (done) tcnt <= '0;
            else      tcnt <= tcnt + TCW'(1);
         end

         if (done && state == BUSY_D) begin
            if (abort)      d_rdata <= '0;
            else if (!m_we) d_rdata <= m_rdata;
         end

         if (done && state == BUSY_I) begin
            if (abort) i_rdata <= '0;
            else       i_rdata <= m_rdata;
         end

         if (abort) err <= 1'b1;
      end
   end

endmodule
